// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and integer register file of the 5-stage RV64 pipeline.
//
// Selects between the ALU result and load data, aligns and extends sub-word loads,
// writes the result into a NREG x XLEN register file (x0 hardwired to zero), serves two
// combinational read ports, and counts committed register writes.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   : write-through, a read of the register being written returns WB_Data
//   undefined : the read returns the old value; the new value appears the next cycle
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-low
//   RegWrite_IR4  write enable from MEM/WB
//   MemtoReg_IR4  1 = load data, 0 = ALU result
//   funct3_IR4    load size/sign
//   Read_Data_IR4 raw doubleword from data memory
//   Mem_Addr_IR4  ALU result; [2:0] is the load byte offset
//   instb_IR4     destination register rd
//   rs1, rs2      decode read addresses
//   ReadData1/2   register values for rs1/rs2
//   WB_Data       value being written this cycle
//   wb_count      committed register writes (wraps)

module wb_regfile #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite_IR4,
    input  logic             MemtoReg_IR4,
    input  logic [2:0]       funct3_IR4,
    input  logic [XLEN-1:0]  Read_Data_IR4,
    input  logic [XLEN-1:0]  Mem_Addr_IR4,
    input  logic [4:0]       instb_IR4,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    output logic [XLEN-1:0]  ReadData1,
    output logic [XLEN-1:0]  ReadData2,
    output logic [XLEN-1:0]  WB_Data,
    output logic [CNT_W-1:0] wb_count
);

    logic [XLEN-1:0]  regs_q [NREG];
    logic [XLEN-1:0]  regs_d [NREG];
    logic [CNT_W-1:0] wb_count_q, wb_count_d;
    logic [XLEN-1:0]  load_shifted;
    logic [XLEN-1:0]  load_data;
    logic             wr_en;

    // Bytes shifted in from above bit XLEN-1 are zero, so misaligned loads read 0 there.
    assign load_shifted = Read_Data_IR4 >> {Mem_Addr_IR4[2:0], 3'b000};

    always_comb begin
        load_data = Read_Data_IR4;
        unique case (funct3_IR4)
            3'b000:  load_data = {{(XLEN-8){load_shifted[7]}},   load_shifted[7:0]};
            3'b001:  load_data = {{(XLEN-16){load_shifted[15]}}, load_shifted[15:0]};
            3'b010:  load_data = {{(XLEN-32){load_shifted[31]}}, load_shifted[31:0]};
            3'b100:  load_data = {{(XLEN-8){1'b0}},  load_shifted[7:0]};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, load_shifted[15:0]};
            3'b110:  load_data = {{(XLEN-32){1'b0}}, load_shifted[31:0]};
            // ld and the undefined encoding 111 take the raw doubleword, offset ignored.
            default: load_data = Read_Data_IR4;
        endcase
    end

    assign WB_Data = MemtoReg_IR4 ? load_data : Mem_Addr_IR4;
    assign wr_en   = RegWrite_IR4 && (instb_IR4 != 5'd0);

    always_comb begin
        for (int i = 0; i < int'(NREG); i++) begin
            regs_d[i] = regs_q[i];
        end
        wb_count_d = wb_count_q;
        if (wr_en) begin
            regs_d[instb_IR4] = WB_Data;
            wb_count_d        = wb_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
            wb_count_q <= '0;
        end else begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= regs_d[i];
            end
            wb_count_q <= wb_count_d;
        end
    end

`ifdef WB_BYPASS_EN
    logic byp1, byp2;
    assign byp1 = wr_en && reset && (rs1 == instb_IR4);
    assign byp2 = wr_en && reset && (rs2 == instb_IR4);

    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if (rs1 != 5'd0) ReadData1 = byp1 ? WB_Data : regs_q[rs1];
        if (rs2 != 5'd0) ReadData2 = byp2 ? WB_Data : regs_q[rs2];
    end
`else
    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if (rs1 != 5'd0) ReadData1 = regs_q[rs1];
        if (rs2 != 5'd0) ReadData2 = regs_q[rs2];
    end
`endif

    assign wb_count = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: table of write-back vectors plus hand sequences
// for reset, write-through, x0 and counter wrap. A narrow counter keeps the wrap reachable.

module tb_wb_regfile;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          RegWrite_IR4;
    logic          MemtoReg_IR4;
    logic [2:0]    funct3_IR4;
    logic [63:0]   Read_Data_IR4;
    logic [63:0]   Mem_Addr_IR4;
    logic [4:0]    instb_IR4;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [63:0]   ReadData1;
    logic [63:0]   ReadData2;
    logic [63:0]   WB_Data;
    logic [CW-1:0] wb_count;

    wb_regfile #(.XLEN(64), .NREG(32), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite_IR4  (RegWrite_IR4),
        .MemtoReg_IR4  (MemtoReg_IR4),
        .funct3_IR4    (funct3_IR4),
        .Read_Data_IR4 (Read_Data_IR4),
        .Mem_Addr_IR4  (Mem_Addr_IR4),
        .instb_IR4     (instb_IR4),
        .rs1           (rs1),
        .rs2           (rs2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .WB_Data       (WB_Data),
        .wb_count      (wb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [2:0]  f3;
        logic [63:0] rdata;
        logic [63:0] addr;
        logic [4:0]  rd;
        logic [63:0] exp_wb;
    } vec_t;

    int          nvec  = 0;
    int          nfail = 0;
    logic [63:0] model [32];
    int          exp_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic idle();
        RegWrite_IR4  = 1'b0;
        MemtoReg_IR4  = 1'b0;
        funct3_IR4    = 3'b000;
        Read_Data_IR4 = '0;
        Mem_Addr_IR4  = '0;
        instb_IR4     = '0;
    endtask

    task automatic do_write(input logic [4:0] rd, input logic [63:0] val);
        @(negedge clk);
        RegWrite_IR4 = 1'b1;
        MemtoReg_IR4 = 1'b0;
        Mem_Addr_IR4 = val;
        instb_IR4    = rd;
        @(posedge clk);
        #1;
        idle();
    endtask

    vec_t vecs [15];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 3'b000, 64'h0, 64'h1234, 5'd7, 64'h1234};
        vecs[1]  = '{1'b1, 1'b1, 3'b000, 64'h80FF_0000_0000_0000, 64'h7, 5'd3,
                     64'hFFFF_FFFF_FFFF_FF80};
        vecs[2]  = '{1'b1, 1'b1, 3'b100, 64'h80FF_0000_0000_0000, 64'h7, 5'd3, 64'h80};
        vecs[3]  = '{1'b1, 1'b0, 3'b000, 64'h0, 64'h55, 5'd0, 64'h55};
        vecs[4]  = '{1'b1, 1'b1, 3'b001, 64'h80FF_0000_0000_0000, 64'h6, 5'd4,
                     64'hFFFF_FFFF_FFFF_80FF};
        vecs[5]  = '{1'b1, 1'b1, 3'b101, 64'h80FF_0000_0000_0000, 64'h6, 5'd5, 64'h80FF};
        vecs[6]  = '{1'b1, 1'b1, 3'b010, 64'h80FF_0000_0000_0000, 64'h6, 5'd6, 64'h80FF};
        vecs[7]  = '{1'b1, 1'b1, 3'b010, 64'h8765_4321_0000_0000, 64'h4, 5'd8,
                     64'hFFFF_FFFF_8765_4321};
        vecs[8]  = '{1'b1, 1'b1, 3'b110, 64'h8765_4321_0000_0000, 64'h4, 5'd10,
                     64'h8765_4321};
        vecs[9]  = '{1'b1, 1'b1, 3'b011, 64'h0123_4567_89AB_CDEF, 64'h5, 5'd11,
                     64'h0123_4567_89AB_CDEF};
        vecs[10] = '{1'b1, 1'b1, 3'b111, 64'h0123_4567_89AB_CDEF, 64'h3, 5'd12,
                     64'h0123_4567_89AB_CDEF};
        vecs[11] = '{1'b0, 1'b0, 3'b000, 64'h0, 64'h999, 5'd13, 64'h999};
        vecs[12] = '{1'b1, 1'b1, 3'b000, 64'h0000_0000_0000_017F, 64'h0, 5'd14, 64'h7F};
        vecs[13] = '{1'b1, 1'b1, 3'b100, 64'h0000_0000_0000_F000, 64'h1, 5'd15, 64'hF0};
        vecs[14] = '{1'b1, 1'b1, 3'b001, 64'h0000_0000_7FFF_0000, 64'h2, 5'd16, 64'h7FFF};

        for (int i = 0; i < 32; i++) model[i] = '0;
        idle();
        rs1   = '0;
        rs2   = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Reset state
        rs1 = 5'd7;
        rs2 = 5'd31;
        #1;
        check("reset_rd1", ReadData1, 64'h0);
        check("reset_rd2", ReadData2, 64'h0);
        check("reset_cnt", {60'h0, wb_count}, 64'h0);

        // Table-driven write-back vectors
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            RegWrite_IR4  = vecs[i].rw;
            MemtoReg_IR4  = vecs[i].m2r;
            funct3_IR4    = vecs[i].f3;
            Read_Data_IR4 = vecs[i].rdata;
            Mem_Addr_IR4  = vecs[i].addr;
            instb_IR4     = vecs[i].rd;
            rs1 = 5'd1;
            rs2 = 5'd2;
            #1;
            check($sformatf("v%0d_wbdata", i), WB_Data, vecs[i].exp_wb);
            if (vecs[i].rw && vecs[i].rd != 5'd0) begin
                model[vecs[i].rd] = vecs[i].exp_wb;
                exp_cnt = (exp_cnt + 1) % (1 << CW);
            end
            @(posedge clk);
            #1;
            idle();
            rs1 = vecs[i].rd;
            rs2 = 5'd0;
            #1;
            check($sformatf("v%0d_rd1", i), ReadData1, model[vecs[i].rd]);
            check($sformatf("v%0d_rs2_x0", i), ReadData2, 64'h0);
            check($sformatf("v%0d_cnt", i), {60'h0, wb_count}, 64'(exp_cnt));
        end

        // Both ports on the same register
        @(negedge clk);
        rs1 = 5'd3;
        rs2 = 5'd3;
        #1;
        check("same_rd1", ReadData1, 64'h80);
        check("same_rd2", ReadData2, 64'h80);
        rs2 = 5'd4;
        #1;
        check("other_rd2", ReadData2, 64'hFFFF_FFFF_FFFF_80FF);

        // Write x9 while reading it in the same cycle
        @(negedge clk);
        RegWrite_IR4 = 1'b1;
        Mem_Addr_IR4 = 64'hA;
        instb_IR4    = 5'd9;
        rs1 = 5'd9;
        rs2 = 5'd7;
        #1;
`ifdef WB_BYPASS_EN
        check("bypass_same_cycle", ReadData1, 64'hA);
`else
        check("nobypass_same_cycle", ReadData1, 64'h0);
`endif
        check("bypass_other_reg", ReadData2, 64'h1234);
        @(posedge clk);
        #1;
        idle();
        #1;
        check("x9_next_cycle", ReadData1, 64'hA);
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        check("x9_cnt", {60'h0, wb_count}, 64'(exp_cnt));

        // Drive the counter to all-ones, then one more write wraps it
        while (exp_cnt != (1 << CW) - 1) begin
            do_write(5'd20, 64'(exp_cnt));
            exp_cnt++;
        end
        check("cnt_max", {60'h0, wb_count}, 64'((1 << CW) - 1));
        do_write(5'd21, 64'h77);
        check("cnt_wrap", {60'h0, wb_count}, 64'h0);
        rs1 = 5'd21;
        #1;
        check("wrap_write_data", ReadData1, 64'h77);

        // Reset held two cycles with a write presented during it
        do_write(5'd5, 64'hDEAD);
        rs1 = 5'd5;
        #1;
        check("x5_before_reset", ReadData1, 64'hDEAD);
        @(negedge clk);
        reset        = 1'b0;
        RegWrite_IR4 = 1'b1;
        Mem_Addr_IR4 = 64'hBEEF;
        instb_IR4    = 5'd6;
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle();
        reset = 1'b1;
        rs1 = 5'd5;
        rs2 = 5'd6;
        #1;
        check("post_reset_x5", ReadData1, 64'h0);
        check("post_reset_x6", ReadData2, 64'h0);
        check("post_reset_cnt", {60'h0, wb_count}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
